// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: accept in IDLE, drive ALU in EXEC, hold response in RESP.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_cout,
  output logic             resp_err,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [2:0]       op_ctrl_q, op_ctrl_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic grant0, grant1, op_err;

  // Gated by rst_n so readys read 0 for the whole time reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && rst_n) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign op_err = (op_ctrl_q == 3'b011) || (op_ctrl_q == 3'b100) || (op_ctrl_q == 3'b101);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_ctrl_d = op_ctrl_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_id_d   = op_id_q;
    res_d     = res_q;
    zero_d    = zero_q;
    cout_d    = cout_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          op_ctrl_d = grant1 ? req1_ctrl : req0_ctrl;
          op_a_d    = grant1 ? req1_a : req0_a;
          op_b_d    = grant1 ? req1_b : req0_b;
          op_id_d   = grant1;
          ptr_d     = ~grant1;
          state_d   = StExec;
        end
      end
      StExec: begin
        res_d   = op_err ? '0 : alu_result;
        zero_d  = op_err ? 1'b0 : alu_zero;
        cout_d  = op_err ? 1'b0 : alu_cout;
        err_d   = op_err;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      op_ctrl_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      op_ctrl_q <= op_ctrl_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_id_q   <= op_id_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp_valid  = (state_q == StResp);
  assign resp_id     = op_id_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp_cout   = cout_q;
  assign resp_err    = err_q;
  assign alu_ctrl    = (state_q == StExec) ? op_ctrl_q : 3'b000;
  assign alu_a       = (state_q == StExec) ? op_a_q : '0;
  assign alu_b       = (state_q == StExec) ? op_b_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hooked to the alu_* ports.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, resp_ready;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_ctrl, req1_ctrl;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_id, resp_zero, resp_cout, resp_err;
  logic [WIDTH-1:0] resp_result;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero, alu_cout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_cout(resp_cout),
    .resp_err(resp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  // Illegal codes return junk with flags set so forcing-to-zero is observable.
  logic [WIDTH:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    unique case (alu_ctrl)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[WIDTH-1:0];
        alu_cout   = sum[WIDTH];
      end
      3'b110: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
        alu_result = sum[WIDTH-1:0];
        alu_cout   = sum[WIDTH];
      end
      3'b111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 1 : 0;
      default: begin
        alu_result = 32'hDEAD_BEEF;
        alu_cout   = 1'b1;
      end
    endcase
    alu_zero = (alu_result == '0) || (alu_ctrl inside {3'b011, 3'b100, 3'b101});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_ctrl = 3'b001; req1_a = 32'd3; req1_b = 32'd4;
    tick();
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_result, alu_ctrl, alu_a} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: r0=%b r1=%b rv=%b res=%h ctrl=%b a=%h, want all 0",
               req0_ready, req1_ready, resp_valid, resp_result, alu_ctrl, alu_a);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_priority: readys=%b want 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (alu_ctrl !== 3'b010 || alu_a !== 32'd1) begin
      failures++;
      $display("FAIL reset_exec_setup: ctrl=%b a=%h want 010/1", alu_ctrl, alu_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_ctrl, alu_a, alu_b, resp_valid, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid_exec: ctrl=%b a=%h b=%h rv=%b, want 0",
               alu_ctrl, alu_a, alu_b, resp_valid);
    end
    tick();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_resp: cycle %0d resp_valid=%b want 0", i, resp_valid);
      end
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    req0_valid = 1'b1; req0_ctrl = 3'b010; req0_a = 32'd6; req0_b = 32'd5;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_grant: readys=%b want 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req0_a = 32'd99;
    checks++;
    if (resp_valid !== 1'b0 || alu_ctrl !== 3'b010 || alu_a !== 32'd6 || alu_b !== 32'd5) begin
      failures++;
      $display("FAIL single_exec: rv=%b ctrl=%b a=%0d b=%0d want 0/010/6/5",
               resp_valid, alu_ctrl, alu_a, alu_b);
    end
    tick();
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err} !== {2'b10, 32'd11, 2'b00}) begin
      failures++;
      $display("FAIL single_resp: v=%b id=%b res=%0d z=%b e=%b want 1/0/11/0/0",
               resp_valid, resp_id, resp_result, resp_zero, resp_err);
    end
    checks++;
    if (alu_ctrl !== 3'b000 || alu_a !== '0) begin
      failures++;
      $display("FAIL single_alu_idle: ctrl=%b a=%h want 0", alu_ctrl, alu_a);
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drop: resp_valid=%b want 0", resp_valid);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_alternate;
    logic g;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctrl = 3'b110; req0_a = 32'd6; req0_b = 32'd6;
    req1_valid = 1'b1; req1_ctrl = 3'b001; req1_a = 32'd6; req1_b = 32'd5;
    g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL alt_grant%0d: readys=%b want grant %0d", i, {req0_ready, req1_ready}, g);
      end
      tick();
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        failures++;
        $display("FAIL alt_exec_ready%0d: readys=%b want 00", i, {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if (!g && {resp_valid, resp_id, resp_result, resp_zero} !== {2'b10, 32'd0, 1'b1}) begin
        failures++;
        $display("FAIL alt_resp%0d: v=%b id=%b res=%0d z=%b want 1/0/0/1",
                 i, resp_valid, resp_id, resp_result, resp_zero);
      end else if (g && {resp_valid, resp_id, resp_result, resp_zero} !== {2'b11, 32'd7, 1'b0})
      begin
        failures++;
        $display("FAIL alt_resp%0d: v=%b id=%b res=%0d z=%b want 1/1/7/0",
                 i, resp_valid, resp_id, resp_result, resp_zero);
      end
      tick();
      g = ~g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00;
    tick();
    req1_valid = 1'b1; req1_ctrl = 3'b010; req1_a = 32'd1; req1_b = 32'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h0000_F000 || resp_id !== 1'b0
          || {req0_ready, req1_ready} !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%b res=%h id=%b readys=%b want 1/0000f000/0/00",
                 i, resp_valid, resp_result, resp_id, {req0_ready, req1_ready});
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: v=%b r1=%b want 0/1", resp_valid, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic test_illegal;
    do_reset();
    req1_valid = 1'b1; req1_ctrl = 3'b100; req1_a = 32'd3; req1_b = 32'd4;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL ill_grant: readys=%b want 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if (alu_ctrl !== 3'b100 || alu_a !== 32'd3 || alu_b !== 32'd4) begin
      failures++;
      $display("FAIL ill_exec: ctrl=%b a=%0d b=%0d want 100/3/4", alu_ctrl, alu_a, alu_b);
    end
    tick();
    checks++;
    if ({resp_valid, resp_id, resp_err, resp_result, resp_zero, resp_cout}
        !== {3'b111, 32'd0, 2'b00}) begin
      failures++;
      $display("FAIL ill_resp: v=%b id=%b e=%b res=%h z=%b c=%b want 1/1/1/0/0/0",
               resp_valid, resp_id, resp_err, resp_result, resp_zero, resp_cout);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_slt;
    do_reset();
    resp_ready = 1'b1;
    req0_ctrl = 3'b111;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1;
      req0_a = (i == 0) ? 32'd5 : 32'd6;
      req0_b = (i == 0) ? 32'd6 : 32'd5;
      #1;
      checks++;
      if (alu_ctrl !== 3'b000 || alu_a !== '0 || alu_b !== '0) begin
        failures++;
        $display("FAIL slt_idle_alu%0d: ctrl=%b a=%h b=%h want 0", i, alu_ctrl, alu_a, alu_b);
      end
      tick();
      req0_valid = 1'b0;
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== ((i == 0) ? 32'd1 : 32'd0)
          || resp_err !== 1'b0 || alu_a !== '0) begin
        failures++;
        $display("FAIL slt_resp%0d: v=%b res=%0d e=%b alu_a=%h want 1/%0d/0/0",
                 i, resp_valid, resp_result, resp_err, alu_a, (i == 0) ? 1 : 0);
      end
      tick();
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_slt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
